// File: rtl/arith_pkg.sv
// arith_pkg: shared FSM encoding and step/counter sizing helpers for serial_add_sub.
package arith_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  function automatic int steps_f(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int cnt_w_f(input int width, input int digit);
    return $clog2(width / digit) < 1 ? 1 : $clog2(width / digit);
  endfunction
endpackage

// File: rtl/fa_bit.sv
// fa_bit: 1-bit full adder cell used to build the per-cycle digit chain.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle add/subtract, DIGIT bits per cycle with a registered inter-digit carry.
module serial_add_sub
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STEPS = steps_f(WIDTH, DIGIT);
  localparam int CW    = cnt_w_f(WIDTH, DIGIT);
  if (WIDTH < 2 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad
    $error("serial_add_sub: WIDTH must be >= 2 and a multiple of DIGIT");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d, sum_sh;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] ds;
  assign c[0] = carry_q;
  for (genvar i = 0; i < DIGIT; i++) begin : g_chain
    fa_bit u_fa (.a(a_q[i]), .b(b_q[i]), .cin(c[i]), .s(ds[i]), .cout(c[i+1]));
  end
  // Digit sums enter from the MSB side so the first digit ends up in the LSBs.
  if (DIGIT == WIDTH) begin : g_sh_full
    assign sum_sh = ds;
  end else begin : g_sh_part
    assign sum_sh = {ds, sum_q[WIDTH-1:DIGIT]};
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && start) begin
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = sub ? ~cin : cin;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      a_d     = a_q >> DIGIT;
      b_d     = b_q >> DIGIT;
      sum_d   = sum_sh;
      carry_d = c[DIGIT];
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CW'(STEPS - 1)) begin
        cout_d  = c[DIGIT];
        ovf_d   = c[DIGIT-1] ^ c[DIGIT];
        state_d = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: lockstep check of several (WIDTH, DIGIT) instances against an arithmetic model.
module tb_serial_add_sub;
  localparam int N = 6;
  localparam int WS [N] = '{8, 8, 8, 4, 16, 16};
  localparam int DS [N] = '{1, 4, 2, 1, 4, 16};
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [15:0] a_in = '0, b_in = '0;
  logic        busy_o [N], done_o [N], cout_o [N], ovf_o [N];
  logic [15:0] sum_o [N];
  int          n_chk = 0, n_fail = 0, n_overlap = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = WS[g];
    logic [W-1:0] s;
    serial_add_sub #(.WIDTH(W), .DIGIT(DS[g])) u_dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .cin(cin),
      .a(a_in[W-1:0]), .b(b_in[W-1:0]),
      .busy(busy_o[g]), .done(done_o[g]), .sum(s), .cout(cout_o[g]), .ovf(ovf_o[g])
    );
    assign sum_o[g] = 16'(s);
  end
  always @(negedge clk)
    for (int i = 0; i < N; i++) if (busy_o[i] && done_o[i]) n_overlap++;
  task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%0h expected=%0h", tag, idx, got, exp);
    end
  endtask
  function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv, input logic sv,
                                input logic cv, output logic [15:0] es, output logic ec, output logic eo);
    longint m  = longint'(1) << w;
    longint ua = longint'(av) & (m - 1);
    longint ub = longint'(bv) & (m - 1);
    longint sa = ua >= m / 2 ? ua - m : ua;
    longint sb = ub >= m / 2 ? ub - m : ub;
    longint r  = sv ? sa - sb - longint'(cv) : sa + sb + longint'(cv);
    longint ur = sv ? ua - ub - longint'(cv) : ua + ub + longint'(cv);
    eo = r < -(m / 2) || r >= m / 2;
    ec = sv ? ur >= 0 : ur >= m;
    es = 16'((ur + m) & (m - 1));
  endfunction
  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic sv, input logic cv, input bit inj);
    int lat [N];
    int nd [N];
    logic [15:0] es;
    logic ec, eo;
    for (int i = 0; i < N; i++) begin lat[i] = -1; nd[i] = 0; end
    a_in = av; b_in = bv; sub = sv; cin = cv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < N; i++) chk("busy_after_accept", i, 32'(busy_o[i]), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      if (inj) begin
        a_in = 16'($urandom); b_in = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        start = k <= 2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < N; i++) if (done_o[i]) begin nd[i]++; if (lat[i] < 0) lat[i] = k; end
    end
    for (int i = 0; i < N; i++) begin
      model(WS[i], av, bv, sv, cv, es, ec, eo);
      chk("done_latency", i, 32'(lat[i]), 32'(WS[i] / DS[i]));
      chk("done_pulses", i, 32'(nd[i]), 32'd1);
      chk("sum", i, 32'(sum_o[i]), 32'(es));
      chk("cout", i, 32'(cout_o[i]), 32'(ec));
      chk("ovf", i, 32'(ovf_o[i]), 32'(eo));
    end
  endtask
  initial begin
    int nd;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_busy", i, 32'(busy_o[i]), 32'd0);
      chk("rst_done", i, 32'(done_o[i]), 32'd0);
      chk("rst_sum", i, 32'(sum_o[i]), 32'd0);
      chk("rst_cout", i, 32'(cout_o[i]), 32'd0);
      chk("rst_ovf", i, 32'(ovf_o[i]), 32'd0);
    end
    rst = 1'b0;
    run_op(16'h005A, 16'h003C, 1'b0, 1'b0, 1'b1);
    chk("w8d1_sum", 0, 32'(sum_o[0]), 32'h96);
    chk("w8d1_cout", 0, 32'(cout_o[0]), 32'd0);
    chk("w8d1_ovf", 0, 32'(ovf_o[0]), 32'd1);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0);
    chk("w8d4_sum", 1, 32'(sum_o[1]), 32'h01);
    chk("w8d4_cout", 1, 32'(cout_o[1]), 32'd1);
    chk("w8d4_ovf", 1, 32'(ovf_o[1]), 32'd0);
    run_op(16'h0080, 16'h0001, 1'b1, 1'b0, 1'b1);
    chk("w8d2_sub_sum", 2, 32'(sum_o[2]), 32'h7F);
    chk("w8d2_sub_cout", 2, 32'(cout_o[2]), 32'd1);
    chk("w8d2_sub_ovf", 2, 32'(ovf_o[2]), 32'd1);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    chk("w8d2_borrow_sum", 2, 32'(sum_o[2]), 32'hFF);
    chk("w8d2_borrow_cout", 2, 32'(cout_o[2]), 32'd0);
    run_op(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0);
    chk("eq_sub_sum", 4, 32'(sum_o[4]), 32'h0);
    chk("eq_sub_cout", 4, 32'(cout_o[4]), 32'd1);
    a_in = 16'h00C3; b_in = 16'h0011; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("abort_busy", i, 32'(busy_o[i]), 32'd0);
      chk("abort_sum", i, 32'(sum_o[i]), 32'd0);
      chk("abort_cout", i, 32'(cout_o[i]), 32'd0);
      chk("abort_ovf", i, 32'(ovf_o[i]), 32'd0);
    end
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N; i++) nd += int'(done_o[i]);
      @(posedge clk); #1;
    end
    chk("abort_no_done", 0, 32'(nd), 32'd0);
    run_op(16'h00C3, 16'h0011, 1'b0, 1'b0, 1'b0);
    for (int t = 0; t < 1000; t++)
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    chk("busy_done_overlap", 0, 32'(n_overlap), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised multi-cycle adder/subtractor, the sequential successor to the team's 4-bit ripple-carry adder. It processes `DIGIT` bits per clock through a `DIGIT`-wide full-adder chain, iterating `WIDTH/DIGIT` times, with a registered carry between digits. It offers add and subtract modes with carry/borrow-in, plus carry-out and signed-overflow flags. A start/done handshake sits between operand sources (DIP/switch front-end or datapath) and result display/consumers.

## Interface
- `WIDTH`, 8: operand and result width in bits. Must be at least 2.
- `DIGIT`, 1: bits processed per cycle. `WIDTH % DIGIT == 0` is required; an illegal value is an elaboration error.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  request. Sampled only in IDLE.
- `sub`  in  1  0 = add (a + b + cin); 1 = subtract (a − b − cin, cin acts as borrow-in).
- `cin`  in  1  carry-in / borrow-in.
- `a`, `b`  in  WIDTH  operands. Latched on accepted start.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when the result is valid.
- `sum`  out  WIDTH  result.
- `cout`  out  1  raw carry out of the MSB. In sub mode, borrow-out = ~cout.
- `ovf`  out  1  two's-complement overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE, with start=1:
  - Latch `a`.
  - Latch `b` XOR {WIDTH{sub}}.
  - Set carry register to `sub ? ~cin : cin`.
  - Clear step counter. Go to RUN.
- IDLE, with start=0: stay in IDLE.
- RUN, every cycle:
  - Add the low `DIGIT` bits of the operand shift registers plus the carry register through the `DIGIT`-bit chain.
  - Shift the digit sum into `sum` from the MSB side.
  - Shift both operands right by `DIGIT`.
  - Store the chain carry-out in the carry register.
  - Increment the counter.
- RUN exit: on the step where counter = STEPS−1 (STEPS = WIDTH/DIGIT), also capture `cout` = chain carry-out and `ovf` = (carry into bit DIGIT−1) XOR (chain carry-out). Then go to DONE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Result persistence: `sum`, `cout`, `ovf` hold their values until the next accepted start. They are not cleared on start; they only update during RUN and on the final step.
- `start` during RUN or DONE is ignored, not queued.
- Changes on `a`, `b`, `sub`, `cin` after acceptance have no effect on the running operation.
- Arithmetic: results are modulo 2^WIDTH. No saturation.
- Subtract mode: a=b, cin=0 → sum=0, cout=1.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0. Counter, carry, and operand registers are all 0.
- Reset mid-RUN or mid-DONE aborts the operation with no done pulse. All outputs take their reset values on the next edge.
- `rst` has priority over `start` in the same cycle.
- Latency:
  - Start sampled at edge E.
  - `busy`=1 from E through E+STEPS.
  - `done`=1 in the cycle following edge E+STEPS (i.e. between edges E+STEPS and E+STEPS+1).
  - Total STEPS+1 cycles from accept to done.
- Throughput: a new start is accepted no earlier than the cycle after `done`, i.e. one operation per STEPS+2 cycles.
- `busy` and `done` are never high together.
- All outputs are registered. No combinational input→output paths.
- Critical path: the `DIGIT`-bit ripple chain, roughly 2 gate delays per bit.

## Structure
- Shared package `arith_pkg`:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - Function computing STEPS and counter width, i.e. clog2(STEPS), minimum 1.
- Sub-module `fa_bit`: 1-bit full adder.
  - s = a ^ b ^ cin
  - cout = (a & b) | (cin & (a ^ b))
  - Instanced DIGIT times by generate to form the per-cycle chain.
- Top level holds the FSM, counter, operand/result shift registers, and carry register.

## Test plan
- WIDTH=8, DIGIT=1, add: a=0x5A, b=0x3C, cin=0 → sum=0x96, cout=0, ovf=1. `done` arrives exactly 9 cycles after start.
- WIDTH=8, DIGIT=4, add: a=0xFF, b=0x01, cin=1 → sum=0x01, cout=1, ovf=0. `done` arrives 3 cycles after start.
- WIDTH=8, DIGIT=2, subtract: a=0x80, b=0x01, cin=0 → sum=0x7F, cout=1, ovf=1. Then a=0x00, b=0x00, cin=1 → sum=0xFF, cout=0 (borrow out).
- Start pulsed during RUN with different operands → ignored. The first result completes unchanged and only one `done` pulse occurs.
- Assert `rst` at step 3 of an 8-step operation → busy=0, sum=0, cout=0, ovf=0 next cycle. No `done` pulse. A new start then completes normally.
- Randomised 1000 operations for each (WIDTH, DIGIT) in {(4,1), (8,2), (16,4), (16,16)} against a reference model. Operand changes are injected mid-RUN and must have no effect.
